uart_fifo_device: RTL and testbench
===================================

// Module: uart_fifo_device
// PURPOSE
//  Buffered, parametrised UART peripheral on the Z80 I/O bus: TX FIFO, 16x-oversampled RX with RX FIFO,
//  runtime baud divisor, sticky error flags, RX-available interrupt. Next generation of the TX-only
//  UART port; replaces the start-strobe register with FIFO push/pop and adds full receive.
// PARAMETERS
//  BASE_ADDR  8'h10  I/O base; four registers at BASE_ADDR+0..+3
//  DATA_BITS  8      frame data bits, legal 5..8; LSB first; unused high bits read 0
//  STOP_BITS  1      1 or 2 stop bits, TX only; RX checks first stop bit only
//  TX_DEPTH   16     TX FIFO entries, power of 2, >=2
//  RX_DEPTH   16     RX FIFO entries, power of 2, >=2
//  DIV_RESET  8'd13  reset divisor; oversample tick every DIV+1 clks (25 MHz/14/16 ~ 111.6 kbaud)
// PORTS
//  clk       in   1  system clock
//  rst       in   1  async active-high reset
//  enable    in   1  I/O select from bus decoder
//  address   in   8  I/O port address
//  write     in   1  1 = write access, 0 = read access
//  dbus_in   in   8  write data
//  dbus_out  out  8  read data; 0 when this block is not addressed
//  rx        in   1  serial input, asynchronous, idle high
//  tx        out  1  serial output, idle high
//  irq       out  1  registered; 1 while RX FIFO not empty
// BEHAVIOUR
//  Reset: tx=1, irq=0, dbus_out=0, both FIFOs empty, DIV=DIV_RESET, sticky flags 0, FSMs IDLE.
//   Reset is async: tx returns to 1 immediately, even mid-frame.
//  Access strobe: acc = enable && address==BASE_ADDR+n. Write effects act once per access, on the first clk
//   of acc&&write. RX pop acts once per access, on the first clk after acc&&!write deasserts.
//  Registers:
//   +0 STATUS  R: b0 tx_busy (FSM!=IDLE or TX FIFO not empty), b1 tx_full, b2 rx_avail, b3 overrun, b4 frame_err
//              W: writing 1 to b3/b4 clears that flag; a set event in the same cycle wins
//   +1 TXDATA  W: push to TX FIFO; silently dropped if full. R: last value written (reset 0)
//   +2 RXDATA  R: RX FIFO head, combinational; 0 if empty; pop on access end; pop on empty = no-op
//   +3 DIV     R/W: 8-bit divisor, takes effect at next tick-counter reload
//   Other addresses: dbus_out=0, no side effects.
//  Tick gen: down-counter loaded with DIV; tick=1 for one clk at 0, then reload. Free-running.
//  TX FSM IDLE->START->DATA->STOP->IDLE; each bit = 16 ticks.
//   IDLE pops FIFO when non-empty on a tick; START drives 0; DATA shifts DATA_BITS bits LSB first;
//   STOP drives 1 for STOP_BITS bits. Back-to-back frames: no idle gap.
//  RX: 2-flop synchroniser on rx. FSM IDLE->START->DATA->STOP->IDLE.
//   IDLE: sync'd 1->0 starts tick counting. START: at tick 8, if line is 1 -> IDLE (glitch, no flag).
//   DATA: sample every 16 ticks. STOP: sample; 0 sets frame_err, byte still pushed.
//   Push into full RX FIFO: byte dropped, overrun set. Push+pop same clk on a full FIFO: both succeed.
//   After STOP with line 0: wait for line 1 before re-arming IDLE.
//  irq = registered rx_avail, 1-clk latency after push/pop.
// STRUCTURE
//  Package uart_pkg: register offsets (REG_STATUS=0, REG_TX=1, REG_RX=2, REG_DIV=3),
//   STATUS bit indices, TX/RX FSM state encodings.
//  Sub-module sync_fifo #(WIDTH, DEPTH): push/pop/full/empty/head, simultaneous push+pop legal.
//   Instantiated twice. Tick generator, TX FSM and RX FSM stay inline.
// TESTING
//  1 Reset values: read +0..+3 -> 8'h00,00,00,0D; tx=1; irq=0.
//  2 DIV=0: write 8'h55 to +1 -> tx: start bit 0 for 16 clks, then 1,0,1,0,1,0,1,0 (16 clks each),
//    then 1; b0 reads 1 until stop bit ends.
//  3 Push 17 bytes with TX_DEPTH=16 while busy -> b1=1 after 16th; 17th dropped; 16 frames sent in order.
//  4 Loop tx->rx, send 8'hA3 -> irq=1, +2 reads A3; after pop irq=0, b2=0.
//  5 Drive 17 frames into rx without popping -> 16 stored, b3=1; write 8'h08 to +0 -> b3=0.
//  6 Frame with stop bit 0 -> b4=1, byte stored; 4-tick low glitch -> no byte, no flag;
//    rst mid-TX frame -> tx=1 at once, FIFOs empty.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the buffered UART peripheral: register map,
// STATUS bit positions and FSM state encodings.
package uart_pkg;

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_TX     = 2'd1;
   localparam logic [1:0] REG_RX     = 2'd2;
   localparam logic [1:0] REG_DIV    = 2'd3;

   localparam int unsigned ST_TX_BUSY   = 0;
   localparam int unsigned ST_TX_FULL   = 1;
   localparam int unsigned ST_RX_AVAIL  = 2;
   localparam int unsigned ST_OVERRUN   = 3;
   localparam int unsigned ST_FRAME_ERR = 4;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_fifo_device_if.sv
// Z80 I/O bus as seen by the UART peripheral; the decoder/CPU side is master.
interface uart_fifo_device_if;
   logic       enable;
   logic [7:0] address;
   logic       write;
   logic [7:0] dbus_in;
   logic [7:0] dbus_out;

   modport master (output enable, address, write, dbus_in, input dbus_out);
   modport slave  (input enable, address, write, dbus_in, output dbus_out);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; push and pop in the same cycle
// are legal, including on a full FIFO.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr, rptr;
   logic             do_push, do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rptr[AW-1:0]];

   always_ff @(posedge clk)
      if (do_push) mem[wptr[AW-1:0]] <= data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end
endmodule

// File: rtl/uart_fifo_device.sv
// Buffered UART on the Z80 I/O bus: TX/RX FIFOs, 16x oversampling, runtime
// divisor, sticky error flags and an RX-available interrupt.
module uart_fifo_device
   import uart_pkg::*;
#(
   parameter logic [7:0]  BASE_ADDR = 8'h10,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned STOP_BITS = 1,
   parameter int unsigned TX_DEPTH  = 16,
   parameter int unsigned RX_DEPTH  = 16,
   parameter logic [7:0]  DIV_RESET = 8'd13
) (
   input  logic                clk,
   input  logic                rst,
   uart_fifo_device_if.slave   bus,
   input  logic                rx,
   output logic                tx,
   output logic                irq
);
   logic [7:0] offset, div, tick_cnt, txd_last, rd_data;
   logic [3:0] hit, wr_hit, rd_hit, wr_hit_q, rd_hit_q, wr_first;
   logic       tick, overrun, frame_err, overrun_set, frame_err_set;

   logic                 txf_full, txf_empty, tx_pop, tx_frame_end, tx_busy;
   logic [DATA_BITS-1:0] txf_head, tx_sh;
   logic [1:0]           tx_state;
   logic [3:0]           tx_tcnt;
   logic [2:0]           tx_bcnt;

   logic                 rxf_full, rxf_empty, rx_push, rx_pop;
   logic [DATA_BITS-1:0] rxf_head, rx_sh;
   logic [1:0]           rx_state;
   logic [3:0]           rx_tcnt;
   logic [2:0]           rx_bcnt;
   logic                 rx_s1, rx_s2, rx_s3;

   // Per-register access strobes; the registered copies turn a multi-cycle
   // access into one write effect (leading edge) or one pop (trailing edge).
   assign offset = bus.address - BASE_ADDR;
   always_comb begin
      hit = '0;
      if (bus.enable && offset < 8'd4) hit[offset[1:0]] = 1'b1;
   end
   assign wr_hit   = bus.write ? hit : '0;
   assign rd_hit   = bus.write ? '0 : hit;
   assign wr_first = wr_hit & ~wr_hit_q;
   assign rx_pop   = rd_hit_q[REG_RX] && !rd_hit[REG_RX];

   assign tick    = (tick_cnt == '0);
   assign tx_busy = (tx_state != TX_IDLE) || !txf_empty;

   always_comb begin
      rd_data = '0;
      if (rd_hit[REG_STATUS]) begin
         rd_data[ST_TX_BUSY]   = tx_busy;
         rd_data[ST_TX_FULL]   = txf_full;
         rd_data[ST_RX_AVAIL]  = !rxf_empty;
         rd_data[ST_OVERRUN]   = overrun;
         rd_data[ST_FRAME_ERR] = frame_err;
      end
      if (rd_hit[REG_TX])                rd_data = txd_last;
      if (rd_hit[REG_RX] && !rxf_empty)  rd_data = 8'(rxf_head);
      if (rd_hit[REG_DIV])               rd_data = div;
   end
   assign bus.dbus_out = rd_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt  <= DIV_RESET;
         div       <= DIV_RESET;
         txd_last  <= '0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         irq       <= 1'b0;
         wr_hit_q  <= '0;
         rd_hit_q  <= '0;
      end else begin
         tick_cnt <= tick ? div : tick_cnt - 1'b1;
         wr_hit_q <= wr_hit;
         rd_hit_q <= rd_hit;
         irq      <= !rxf_empty;
         if (wr_first[REG_DIV]) div      <= bus.dbus_in;
         if (wr_first[REG_TX])  txd_last <= bus.dbus_in;
         if (overrun_set)
            overrun <= 1'b1;
         else if (wr_first[REG_STATUS] && bus.dbus_in[ST_OVERRUN])
            overrun <= 1'b0;
         if (frame_err_set)
            frame_err <= 1'b1;
         else if (wr_first[REG_STATUS] && bus.dbus_in[ST_FRAME_ERR])
            frame_err <= 1'b0;
      end
   end

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(wr_first[REG_TX]), .pop(tx_pop),
      .data(bus.dbus_in[DATA_BITS-1:0]), .full(txf_full), .empty(txf_empty), .head(txf_head)
   );

   // The FIFO is popped either from IDLE or straight out of the last stop
   // tick, which is what makes back-to-back frames gapless.
   assign tx_frame_end = tick && (tx_state == TX_STOP) && (tx_tcnt == 4'd15)
                         && (tx_bcnt == 3'(STOP_BITS - 1));
   assign tx_pop = !txf_empty && ((tick && tx_state == TX_IDLE) || tx_frame_end);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_tcnt  <= '0;
         tx_bcnt  <= '0;
         tx_sh    <= '0;
         tx       <= 1'b1;
      end else if (tick) begin
         tx_tcnt <= tx_tcnt + 1'b1;
         case (tx_state)
            TX_IDLE: begin
               tx_tcnt <= '0;
               if (tx_pop) begin
                  tx_sh    <= txf_head;
                  tx_state <= TX_START;
                  tx       <= 1'b0;
               end
            end
            TX_START: if (tx_tcnt == 4'd15) begin
               tx_state <= TX_DATA;
               tx_bcnt  <= '0;
               tx       <= tx_sh[0];
            end
            TX_DATA: if (tx_tcnt == 4'd15) begin
               tx_sh <= tx_sh >> 1;
               if (tx_bcnt == 3'(DATA_BITS - 1)) begin
                  tx_state <= TX_STOP;
                  tx_bcnt  <= '0;
                  tx       <= 1'b1;
               end else begin
                  tx_bcnt <= tx_bcnt + 1'b1;
                  tx      <= tx_sh[1];
               end
            end
            TX_STOP: if (tx_tcnt == 4'd15) begin
               if (tx_frame_end) begin
                  tx_bcnt <= '0;
                  if (tx_pop) begin
                     tx_sh    <= txf_head;
                     tx_state <= TX_START;
                     tx       <= 1'b0;
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end else begin
                  tx_bcnt <= tx_bcnt + 1'b1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   assign rx_push       = tick && (rx_state == RX_STOP) && (rx_tcnt == 4'd15);
   assign frame_err_set = rx_push && !rx_s2;
   assign overrun_set   = rx_push && rxf_full && !rx_pop;

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
      .data(rx_sh), .full(rxf_full), .empty(rxf_empty), .head(rxf_head)
   );

   // IDLE arms only on a synchronised 1->0 edge, so a frame ending in a
   // held-low line is not re-triggered until the line has returned high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
         rx_state <= RX_IDLE;
         rx_tcnt  <= '0;
         rx_bcnt  <= '0;
         rx_sh    <= '0;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
         case (rx_state)
            RX_IDLE: if (rx_s3 && !rx_s2) begin
               rx_state <= RX_START;
               rx_tcnt  <= '0;
            end
            RX_START: if (tick) begin
               if (rx_tcnt == 4'd7) begin
                  rx_tcnt  <= '0;
                  rx_bcnt  <= '0;
                  rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  rx_tcnt <= rx_tcnt + 1'b1;
               end
            end
            RX_DATA: if (tick) begin
               rx_tcnt <= rx_tcnt + 1'b1;
               if (rx_tcnt == 4'd15) begin
                  rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                  if (rx_bcnt == 3'(DATA_BITS - 1)) rx_state <= RX_STOP;
                  else                              rx_bcnt  <= rx_bcnt + 1'b1;
               end
            end
            RX_STOP: if (tick) begin
               rx_tcnt <= rx_tcnt + 1'b1;
               if (rx_tcnt == 4'd15) rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_fifo_device.sv
// Randomised self-checking bench for uart_fifo_device against a queue-based
// model of the register map, FIFOs and serial frame format.
module tb_uart_fifo_device;
   localparam logic [7:0] BASE = 8'h10;
   localparam int         TXD  = 16;
   localparam int         RXD  = 16;

   logic clk = 1'b0, rst = 1'b0, rx_drv = 1'b1, loop_en = 1'b0;
   logic rx_line, tx, irq;
   int   total = 0, bad = 0;

   uart_fifo_device_if bus();
   assign rx_line = loop_en ? tx : rx_drv;

   uart_fifo_device #(
      .BASE_ADDR(BASE), .DATA_BITS(8), .STOP_BITS(1),
      .TX_DEPTH(TXD), .RX_DEPTH(RXD), .DIV_RESET(8'd13)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .rx(rx_line), .tx(tx), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
      bus.enable = 1'b1; bus.write = 1'b1; bus.address = addr; bus.dbus_in = data;
      @(negedge clk);
      bus.enable = 1'b0; bus.write = 1'b0;
      @(negedge clk);
   endtask

   task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
      bus.enable = 1'b1; bus.write = 1'b0; bus.address = addr;
      #1 data = bus.dbus_out;
      @(negedge clk);
      bus.enable = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_fast_baud();
      bus_write(BASE + 8'd3, 8'h00);
      repeat (20) @(negedge clk);
   endtask

   // Decodes one frame from tx assuming 16 clocks per bit; returns at mid-stop.
   task automatic capture_frame(output logic [7:0] b, output logic start_b,
                                output logic stop_b, output bit ok);
      b = '0; start_b = 1'b1; stop_b = 1'b0; ok = 0;
      for (int i = 0; i < 400; i++) begin
         if (tx === 1'b0) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) return;
      repeat (8) @(negedge clk);
      start_b = tx;
      for (int i = 0; i < 8; i++) begin
         repeat (16) @(negedge clk);
         b[i] = tx;
      end
      repeat (16) @(negedge clk);
      stop_b = tx;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_b);
      rx_drv = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (16) @(negedge clk);
      end
      rx_drv = stop_b;
      repeat (16) @(negedge clk);
      rx_drv = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] d, exp_v;
      for (int i = 0; i < 4; i++) begin
         exp_v = (i == 3) ? 8'h0D : 8'h00;
         bus_read(8'(BASE + 8'(i)), d);
         total++;
         if (d !== exp_v) begin bad++; $display("FAIL reset_reg%0d got=%h exp=%h", i, d, exp_v); end
      end
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
      bus_read(BASE + 8'd4, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL unmapped_hi got=%h exp=00", d); end
      bus_read(BASE - 8'd1, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL unmapped_lo got=%h exp=00", d); end
   endtask

   task automatic test_tx_frame();
      logic [7:0] b, d, cap;
      logic s0, s1;
      bit ok;
      bus_write(BASE + 8'd3, 8'h00);
      bus_read(BASE + 8'd3, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL div_rw got=%h exp=00", d); end
      repeat (20) @(negedge clk);
      for (int n = 0; n < 4; n++) begin
         b = (n == 0) ? 8'h55 : 8'($urandom);
         bus_write(BASE + 8'd1, b);
         capture_frame(cap, s0, s1, ok);
         total++;
         if (!ok) begin bad++; $display("FAIL tx_start_timeout got=none exp=start_bit"); continue; end
         total++; if (s0 !== 1'b0) begin bad++; $display("FAIL tx_start_bit got=%b exp=0", s0); end
         total++; if (cap !== b) begin bad++; $display("FAIL tx_data got=%h exp=%h", cap, b); end
         total++; if (s1 !== 1'b1) begin bad++; $display("FAIL tx_stop_bit got=%b exp=1", s1); end
         bus_read(BASE, d);
         total++; if (d[0] !== 1'b1) begin bad++; $display("FAIL tx_busy_in_stop got=%b exp=1", d[0]); end
         repeat (12) @(negedge clk);
         bus_read(BASE, d);
         total++; if (d[0] !== 1'b0) begin bad++; $display("FAIL tx_busy_after got=%b exp=0", d[0]); end
         bus_read(BASE + 8'd1, d);
         total++; if (d !== b) begin bad++; $display("FAIL txdata_readback got=%h exp=%h", d, b); end
      end
   endtask

   task automatic test_tx_fifo_full();
      logic [7:0] sent[$];
      logic [7:0] got[$];
      logic [7:0] d, b, st;
      logic s0, s1;
      bit ok, exp_full;
      int bad_stop = 0;
      set_fast_baud();
      fork
         begin
            for (int f = 0; f < 18; f++) begin
               capture_frame(b, s0, s1, ok);
               if (!ok) break;
               got.push_back(b);
               if (s0 !== 1'b0 || s1 !== 1'b1) bad_stop++;
            end
         end
         begin
            // first byte goes straight into the shifter; the rest see a TXD-deep FIFO
            for (int k = 0; k < 18; k++) begin
               d = 8'($urandom);
               bus_write(BASE + 8'd1, d);
               if (k == 0 || sent.size() - 1 < TXD) sent.push_back(d);
               if (k == 15 || k == 16) begin
                  exp_full = (sent.size() - 1 >= TXD);
                  bus_read(BASE, st);
                  total++;
                  if (st[1] !== exp_full) begin
                     bad++; $display("FAIL tx_full_after_%0d got=%b exp=%b", k, st[1], exp_full);
                  end
               end
            end
         end
      join
      total++;
      if (got.size() != sent.size()) begin
         bad++; $display("FAIL tx_frame_count got=%0d exp=%0d", got.size(), sent.size());
      end
      for (int i = 0; i < got.size() && i < sent.size(); i++) begin
         total++;
         if (got[i] !== sent[i]) begin bad++; $display("FAIL tx_order[%0d] got=%h exp=%h", i, got[i], sent[i]); end
      end
      total++; if (bad_stop != 0) begin bad++; $display("FAIL tx_framing got=%0d exp=0", bad_stop); end
      bus_read(BASE, st);
      total++; if (st[1:0] !== 2'b00) begin bad++; $display("FAIL tx_drained got=%b exp=00", st[1:0]); end
   endtask

   task automatic test_loopback();
      logic [7:0] b, d;
      int waited;
      loop_en = 1'b1;
      set_fast_baud();
      for (int n = 0; n < 3; n++) begin
         b = (n == 0) ? 8'hA3 : 8'($urandom);
         bus_write(BASE + 8'd1, b);
         waited = 0;
         while (irq !== 1'b1 && waited < 600) begin @(negedge clk); waited++; end
         total++; if (irq !== 1'b1) begin bad++; $display("FAIL loop_irq_set got=%b exp=1", irq); end
         bus_read(BASE + 8'd2, d);
         total++; if (d !== b) begin bad++; $display("FAIL loop_rxdata got=%h exp=%h", d, b); end
         repeat (3) @(negedge clk);
         total++; if (irq !== 1'b0) begin bad++; $display("FAIL loop_irq_clear got=%b exp=0", irq); end
         bus_read(BASE, d);
         total++; if ((d & 8'h1C) !== 8'h00) begin bad++; $display("FAIL loop_status got=%h exp=00", d & 8'h1C); end
      end
      loop_en = 1'b0;
   endtask

   task automatic test_rx_overrun();
      logic [7:0] q[$];
      logic [7:0] b, d, exp_v, e;
      bit ovr_m = 0;
      set_fast_baud();
      for (int n = 0; n < 17; n++) begin
         b = 8'($urandom);
         send_rx(b, 1'b1);
         if (q.size() < RXD) q.push_back(b); else ovr_m = 1;
      end
      exp_v = {3'b000, 1'b0, ovr_m, q.size() != 0, 2'b00};
      bus_read(BASE, d);
      total++; if (d !== exp_v) begin bad++; $display("FAIL ovr_status got=%h exp=%h", d, exp_v); end
      total++; if (irq !== (q.size() != 0)) begin bad++; $display("FAIL ovr_irq got=%b exp=1", irq); end
      bus_write(BASE, 8'h08);
      exp_v = {3'b000, 1'b0, 1'b0, q.size() != 0, 2'b00};
      bus_read(BASE, d);
      total++; if (d !== exp_v) begin bad++; $display("FAIL ovr_clear got=%h exp=%h", d, exp_v); end
      while (q.size() != 0) begin
         e = q.pop_front();
         bus_read(BASE + 8'd2, d);
         total++; if (d !== e) begin bad++; $display("FAIL rx_fifo_order got=%h exp=%h", d, e); end
      end
      bus_read(BASE + 8'd2, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL rx_empty_read got=%h exp=00", d); end
      repeat (2) @(negedge clk);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL rx_empty_irq got=%b exp=0", irq); end
   endtask

   task automatic test_rx_errors();
      logic [7:0] b, d;
      set_fast_baud();
      b = 8'($urandom);
      send_rx(b, 1'b0);
      bus_read(BASE, d);
      total++; if ((d & 8'h1C) !== 8'h14) begin bad++; $display("FAIL frame_err_set got=%h exp=14", d & 8'h1C); end
      bus_read(BASE + 8'd2, d);
      total++; if (d !== b) begin bad++; $display("FAIL frame_err_byte got=%h exp=%h", d, b); end
      bus_write(BASE, 8'h10);
      bus_read(BASE, d);
      total++; if ((d & 8'h1C) !== 8'h00) begin bad++; $display("FAIL frame_err_clear got=%h exp=00", d & 8'h1C); end
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (40) @(negedge clk);
      bus_read(BASE, d);
      total++; if ((d & 8'h1C) !== 8'h00) begin bad++; $display("FAIL glitch_status got=%h exp=00", d & 8'h1C); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL glitch_irq got=%b exp=0", irq); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      logic [7:0] cap;
      logic s0, s1;
      bit ok;
      int lows = 0;
      set_fast_baud();
      send_rx(8'($urandom), 1'b1);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
      bus_write(BASE + 8'd1, 8'h00);
      bus_write(BASE + 8'd1, 8'($urandom));
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         if (tx === 1'b0) begin ok = 1; break; end
         @(negedge clk);
      end
      total++; if (!ok) begin bad++; $display("FAIL pre_reset_start got=none exp=start_bit"); end
      repeat (30) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL async_rst_tx got=%b exp=1", tx); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_rst_irq got=%b exp=0", irq); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      bus_read(BASE, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL post_rst_status got=%h exp=00", d); end
      bus_read(BASE + 8'd2, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL post_rst_rxdata got=%h exp=00", d); end
      bus_read(BASE + 8'd3, d);
      total++; if (d !== 8'h0D) begin bad++; $display("FAIL post_rst_div got=%h exp=0d", d); end
      for (int i = 0; i < 200; i++) begin
         if (tx !== 1'b1) lows++;
         @(negedge clk);
      end
      total++; if (lows != 0) begin bad++; $display("FAIL post_rst_tx_idle got=%0d exp=0", lows); end
      cap = '0; s0 = 1'b0; s1 = 1'b0;
   endtask

   initial begin
      bus.enable = 1'b0; bus.write = 1'b0; bus.address = '0; bus.dbus_in = '0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_tx_frame();
      test_tx_fifo_full();
      test_loopback();
      test_rx_overrun();
      test_rx_errors();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
